mmio_uart: RTL and testbench

Memory-mapped UART peripheral on the RiSC-16 core's data-memory port. It decodes a 4-word window at the top of the 16-bit data address space and presents a combinational read path, so the single-cycle core's LW completes in one cycle. Transmit bytes are buffered in a small FIFO and serialised 8N1. Received bytes are deserialised into a holding register. The top level muxes `o_mem_rd_data` against data RAM using `o_sel`.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/mmio_uart_sync_fifo.sv | 48 ++++
 rtl/mmio_uart.sv | 251 +++++++++++++++++++++++++
 tb/tb_mmio_uart.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state types for the memory-mapped UART.
package uart_pkg;

  // Register offsets within the 4-word window (i_mem_addr[1:0])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_TXCNT  = 2'd3;

  // STATUS bit positions
  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_IDLE  = 1;
  localparam int unsigned ST_RX_VALID = 2;
  localparam int unsigned ST_RX_OVR   = 3;
  localparam int unsigned ST_TX_OVF   = 4;
  localparam int unsigned ST_RX_FERR  = 5;

  // CTRL bit positions
  localparam int unsigned CTRL_CLR_RXV = 0;
  localparam int unsigned CTRL_CLR_ERR = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/mmio_uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty judged on pre-edge state.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign o_empty = (o_count == '0);
  assign o_data  = mem[rd_ptr];
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;

  // Pointer and occupancy update
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      o_count <= o_count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  // Storage write; contents need no reset
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_data;
  end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART: register decode, TX FSM fed by a FIFO, RX FSM.
module mmio_uart
  import uart_pkg::*;
#(
  parameter logic [15:0] p_BASE_ADDR = 16'hFFF0,
  parameter int          p_BAUD_DIV  = 434,
  parameter int          p_TX_DEPTH  = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_mem_addr,
  input  logic [15:0] i_mem_wr_data,
  input  logic        i_mem_wr_en,
  output logic [15:0] o_mem_rd_data,
  output logic        o_sel,
  input  logic        i_rx,
  output logic        o_tx
);

  localparam int AW = $clog2(p_TX_DEPTH);
  localparam int BW = $clog2(p_BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(p_BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(p_BAUD_DIV / 2 - 1);

  tx_state_t     tx_state;
  logic [BW-1:0] tx_cnt;
  logic [7:0]    tx_sh;
  logic [2:0]    tx_bit;
  logic          tx_pop;

  rx_state_t     rx_state;
  logic [BW-1:0] rx_cnt;
  logic [7:0]    rx_sh;
  logic [2:0]    rx_bit;
  logic          rx_s1, rx_s2, rx_prev;
  logic [7:0]    rx_byte;
  logic          rx_done_ok, rx_done_bad;

  logic          rx_valid, rx_ovr, tx_ovf, rx_ferr;
  logic          wr_hit, push_req, clr_rxv, clr_err;
  logic [15:0]   status;

  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_count;

  logic          unused_wr_hi;
  assign unused_wr_hi = ^i_mem_wr_data[15:8];

  assign o_sel    = (i_mem_addr[15:2] == p_BASE_ADDR[15:2]);
  assign wr_hit   = o_sel & i_mem_wr_en;
  assign push_req = wr_hit & (i_mem_addr[1:0] == REG_DATA);
  assign clr_rxv  = wr_hit & (i_mem_addr[1:0] == REG_CTRL) & i_mem_wr_data[CTRL_CLR_RXV];
  assign clr_err  = wr_hit & (i_mem_addr[1:0] == REG_CTRL) & i_mem_wr_data[CTRL_CLR_ERR];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (p_TX_DEPTH)
  ) u_txq (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push_req),
    .i_data  (i_mem_wr_data[7:0]),
    .i_pop   (tx_pop),
    .o_data  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // Pop in IDLE or at the last clock of STOP so frames chain without a gap
  always_comb begin
    tx_pop = 1'b0;
    if (!fifo_empty)
      tx_pop = (tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == '0);
  end

  // TX serialiser: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_sh    <= '0;
      tx_bit   <= '0;
      o_tx     <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_sh    <= fifo_dout;
            o_tx     <= 1'b0;
            tx_cnt   <= BAUD_LAST;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            o_tx     <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
            tx_bit   <= '0;
            tx_cnt   <= BAUD_LAST;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt - BW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BAUD_LAST;
            if (tx_bit == 3'd7) begin
              o_tx     <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              o_tx   <= tx_sh[0];
              tx_sh  <= {1'b0, tx_sh[7:1]};
              tx_bit <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - BW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt == '0) begin
            if (tx_pop) begin
              tx_sh    <= fifo_dout;
              o_tx     <= 1'b0;
              tx_cnt   <= BAUD_LAST;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - BW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchroniser plus previous value for falling-edge detect
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= i_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Stop-bit outcome, used by both the byte register and the flags
  always_comb begin
    rx_done_ok  = 1'b0;
    rx_done_bad = 1'b0;
    if (rx_state == RX_STOP && rx_cnt == '0) begin
      rx_done_ok  = rx_s2;
      rx_done_bad = ~rx_s2;
    end
  end

  // RX deserialiser sampling at mid-bit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_sh    <= '0;
      rx_bit   <= '0;
      rx_byte  <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= BAUD_HALF;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_bit   <= '0;
              rx_cnt   <= BAUD_LAST;
              rx_state <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - BW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= BAUD_LAST;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - BW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            if (rx_done_ok) rx_byte <= rx_sh;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt - BW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Status flags: a hardware set on the same edge as a CTRL clear wins
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      tx_ovf   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= rx_done_ok | (rx_valid & ~clr_rxv);
      rx_ovr   <= (rx_done_ok & rx_valid) | (rx_ovr & ~clr_err);
      tx_ovf   <= (push_req & fifo_full) | (tx_ovf & ~clr_err);
      rx_ferr  <= rx_done_bad | (rx_ferr & ~clr_err);
    end
  end

  // Combinational register read path
  always_comb begin
    status                = '0;
    status[ST_TX_FULL]    = fifo_full;
    status[ST_TX_IDLE]    = fifo_empty & (tx_state == TX_IDLE);
    status[ST_RX_VALID]   = rx_valid;
    status[ST_RX_OVR]     = rx_ovr;
    status[ST_TX_OVF]     = tx_ovf;
    status[ST_RX_FERR]    = rx_ferr;
    o_mem_rd_data = '0;
    if (o_sel) begin
      case (i_mem_addr[1:0])
        REG_DATA:   o_mem_rd_data = {8'h00, rx_byte};
        REG_STATUS: o_mem_rd_data = status;
        REG_TXCNT:  o_mem_rd_data = 16'(fifo_count);
        default:    o_mem_rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart.sv
// Directed bench for mmio_uart with p_BAUD_DIV=4, depth 8.
module tb_mmio_uart;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic        wr_en = 1'b0;
  logic [15:0] rd_data;
  logic        sel;
  logic        rx = 1'b1;
  logic        tx;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic        cap_en = 1'b0;
  logic        cap_q[$];

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        chk;
    logic [15:0] exp_rd;
    logic        exp_sel;
  } vec_t;

  vec_t vecs[16];

  mmio_uart #(
    .p_BASE_ADDR (16'hFFF0),
    .p_BAUD_DIV  (4),
    .p_TX_DEPTH  (8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_mem_addr    (addr),
    .i_mem_wr_data (wdata),
    .i_mem_wr_en   (wr_en),
    .o_mem_rd_data (rd_data),
    .o_sel         (sel),
    .i_rx          (rx),
    .o_tx          (tx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cap_en) cap_q.push_back(tx);

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mmio_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr_en = 1'b1;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic mmio_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; wr_en = 1'b0;
    #1 d = rd_data;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int unsigned k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  // One comparison per frame: 40 consecutive captured samples from index start
  task automatic check_frame(input string nm, input int unsigned start, input logic [7:0] b);
    int unsigned bad;
    logic        got;
    logic        want;
    bad = 0; got = 1'b0; want = 1'b0;
    for (int unsigned s = 0; s < 40; s++) begin
      if (start + s >= cap_q.size()) begin
        if (bad == 0) begin got = 1'bx; want = frame_bit(b, s / 4); end
        bad++;
      end else if (cap_q[start + s] !== frame_bit(b, s / 4)) begin
        if (bad == 0) begin got = cap_q[start + s]; want = frame_bit(b, s / 4); end
        bad++;
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d bad samples, first got %b expected %b", nm, bad, got, want);
    end
  endtask

  task automatic check_idle_from(input string nm, input int unsigned start);
    int unsigned lows;
    lows = 0;
    for (int unsigned i = start; i < cap_q.size(); i++) if (cap_q[i] !== 1'b1) lows++;
    n_tests++;
    if (lows != 0 || cap_q.size() <= start) begin
      n_fail++;
      $display("FAIL %s: %0d non-idle samples of %0d, required 0", nm, lows, cap_q.size());
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_b);
    logic v;
    for (int unsigned k = 0; k < 10; k++) begin
      v = (k == 9) ? stop_b : frame_bit(b, k);
      @(negedge clk);
      rx = v;
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_status_bit(input string nm, input int unsigned idx);
    logic [15:0] d;
    logic        seen;
    seen = 1'b0;
    d = '0;
    for (int unsigned c = 0; c < 30 && !seen; c++) begin
      mmio_read(16'hFFF1, d);
      if (d[idx]) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: status bit %0d stayed 0 (status %h), expected 1 within 30 cycles", nm, idx, d);
    end
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  bytes[10];

    //            wr    addr      wdata     chk   exp_rd    sel
    vecs[0]  = '{1'b0, 16'hFFF1, 16'h0000, 1'b1, 16'h0002, 1'b1};
    vecs[1]  = '{1'b0, 16'hFFF0, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[2]  = '{1'b0, 16'hFFF2, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[3]  = '{1'b0, 16'hFFF3, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[4]  = '{1'b0, 16'hFFEF, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vecs[5]  = '{1'b0, 16'hFFF4, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 16'hFFF3, 16'h00AA, 1'b1, 16'h0000, 1'b1};
    vecs[8]  = '{1'b0, 16'hFFF3, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[9]  = '{1'b1, 16'hFFF1, 16'hFFFF, 1'b1, 16'h0002, 1'b1};
    vecs[10] = '{1'b0, 16'hFFF1, 16'h0000, 1'b1, 16'h0002, 1'b1};
    vecs[11] = '{1'b1, 16'hFFF2, 16'h0003, 1'b1, 16'h0000, 1'b1};
    vecs[12] = '{1'b0, 16'hFFF1, 16'h0000, 1'b1, 16'h0002, 1'b1};
    vecs[13] = '{1'b1, 16'hFFE0, 16'h0041, 1'b1, 16'h0000, 1'b0};
    vecs[14] = '{1'b0, 16'hFFF3, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[15] = '{1'b0, 16'hFFF1, 16'h0000, 1'b1, 16'h0002, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Table-driven register decode checks
    for (int unsigned i = 0; i < 16; i++) begin
      @(negedge clk);
      addr = vecs[i].addr; wdata = vecs[i].wdata; wr_en = vecs[i].wr;
      #1;
      if (vecs[i].chk) begin
        check16($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
        check16($sformatf("vec%0d_sel", i), {15'd0, sel}, {15'd0, vecs[i].exp_sel});
      end
      @(posedge clk);
      #1 wr_en = 1'b0;
    end
    check16("reset_tx_idle_high", {15'd0, tx}, 16'h0001);

    // Single byte 0x55: frame starts one cycle after the write
    cap_q.delete();
    mmio_write(16'hFFF0, 16'h0055);
    cap_en = 1'b1;
    mmio_read(16'hFFF1, d);
    check16("status_after_push", d, 16'h0000);
    repeat (45) @(negedge clk);
    #1 cap_en = 1'b0;
    check16("tx55_pre_start", {15'd0, cap_q[0]}, 16'h0001);
    check_frame("tx55_frame", 1, 8'h55);
    check_idle_from("tx55_after", 41);
    mmio_read(16'hFFF1, d);
    check16("status_idle_after_55", d, 16'h0002);

    // Ten back-to-back writes: first popped at once, eight fill the FIFO, last dropped
    for (int unsigned i = 0; i < 10; i++) bytes[i] = 8'(8'h11 * (i + 1) + i);
    cap_q.delete();
    mmio_write(16'hFFF0, {8'h00, bytes[0]});
    cap_en = 1'b1;
    for (int unsigned i = 1; i < 10; i++) mmio_write(16'hFFF0, {8'h00, bytes[i]});
    mmio_read(16'hFFF3, d);
    check16("txcnt_full", d, 16'h0008);
    mmio_read(16'hFFF1, d);
    check16("status_full_ovf", d, 16'h0011);
    repeat (360) @(negedge clk);
    #1 cap_en = 1'b0;
    for (int unsigned f = 0; f < 9; f++)
      check_frame($sformatf("burst_frame%0d", f), 1 + 40 * f, bytes[f]);
    check_idle_from("burst_no_tenth_frame", 361);
    mmio_read(16'hFFF1, d);
    check16("status_ovf_sticky", d, 16'h0012);
    mmio_write(16'hFFF2, 16'h0002);
    mmio_read(16'hFFF1, d);
    check16("status_ovf_cleared", d, 16'h0002);

    // One-clock low glitch on rx must be rejected at the start-bit re-sample
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (12) @(negedge clk);
    mmio_read(16'hFFF1, d);
    check16("rx_glitch_status", d, 16'h0002);

    // Good frame 0xA3
    send_rx(8'hA3, 1'b1);
    wait_status_bit("rx_a3_valid", 2);
    mmio_read(16'hFFF1, d);
    check16("rx_a3_status", d, 16'h0006);
    mmio_read(16'hFFF0, d);
    check16("rx_a3_data", d, 16'h00A3);
    mmio_write(16'hFFF2, 16'h0001);
    mmio_read(16'hFFF1, d);
    check16("rx_valid_cleared", d, 16'h0002);

    // Two frames without ack: overrun, second byte kept
    repeat (4) @(negedge clk);
    send_rx(8'h3C, 1'b1);
    wait_status_bit("rx_3c_valid", 2);
    repeat (4) @(negedge clk);
    send_rx(8'hC5, 1'b1);
    wait_status_bit("rx_ovr_set", 3);
    mmio_read(16'hFFF1, d);
    check16("rx_ovr_status", d, 16'h000E);
    mmio_read(16'hFFF0, d);
    check16("rx_ovr_data", d, 16'h00C5);

    // Framing error: byte discarded
    repeat (4) @(negedge clk);
    send_rx(8'h77, 1'b0);
    wait_status_bit("rx_ferr_set", 5);
    mmio_read(16'hFFF1, d);
    check16("rx_ferr_status", d, 16'h002E);
    mmio_read(16'hFFF0, d);
    check16("rx_ferr_data_kept", d, 16'h00C5);
    mmio_write(16'hFFF2, 16'h0002);
    mmio_read(16'hFFF1, d);
    check16("ctrl2_clears_errs", d, 16'h0006);
    mmio_write(16'hFFF2, 16'h0003);
    mmio_read(16'hFFF1, d);
    check16("ctrl3_clears_all", d, 16'h0002);

    // Asynchronous reset in the middle of a frame with a byte queued
    mmio_write(16'hFFF0, 16'h0000);
    mmio_write(16'hFFF0, 16'h0000);
    repeat (10) @(negedge clk);
    #1 check16("midframe_tx_low", {15'd0, tx}, 16'h0000);
    mmio_read(16'hFFF3, d);
    check16("midframe_txcnt", d, 16'h0001);
    #1 rst = 1'b1;
    #1 check16("reset_tx_high_now", {15'd0, tx}, 16'h0001);
    mmio_read(16'hFFF3, d);
    check16("reset_txcnt_zero", d, 16'h0000);
    mmio_read(16'hFFF1, d);
    check16("reset_status", d, 16'h0002);
    @(negedge clk);
    rst = 1'b0;
    cap_q.delete();
    cap_en = 1'b1;
    repeat (60) @(negedge clk);
    #1 cap_en = 1'b0;
    check_idle_from("no_frame_after_reset", 0);
    mmio_read(16'hFFF0, d);
    check16("reset_rx_byte", d, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
